// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family:
// FSM encoding, requester count and a width helper.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick over 4 requests,
// starting the scan just after last_grant.
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_grant,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    logic [SEL_W-1:0] idx;

    // Scan from farthest to nearest so the nearest set bit wins.
    always_comb begin
        winner = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_grant + SEL_W'(k);
            if (req[idx]) winner = idx;
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_burst_arbiter_4.sv
// Round-robin burst arbiter: 4 requesters share one registered
// output stage; grant is held per burst or until MAX_BURST beats.
module rr_burst_arbiter_4
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req_valid,
    input  logic [3:0]            req_last,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    input  logic [DATA_WIDTH-1:0] req_data2,
    input  logic [DATA_WIDTH-1:0] req_data3,
    output logic [3:0]            req_ready,
    output logic [1:0]            mux_sel,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [1:0]            out_src,
    input  logic                  out_ready
);

    localparam int CNT_W = clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    logic             state;
    logic [SEL_W-1:0] last_grant;
    logic [CNT_W-1:0] beat_cnt;
    logic [SEL_W-1:0] winner;
    logic             any;
    logic             take;
    logic             accept;
    logic             term;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_pick_4 u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any        (any)
    );

    always_comb begin
        unique case (mux_sel)
            2'd0: sel_data = req_data0;
            2'd1: sel_data = req_data1;
            2'd2: sel_data = req_data2;
            2'd3: sel_data = req_data3;
        endcase
    end

    assign take = !out_valid || out_ready;
    assign accept = (state == BUSY) && req_valid[mux_sel] && take;
    assign term = req_last[mux_sel] || (beat_cnt == LAST_CNT);

    always_comb begin
        req_ready = '0;
        if (state == BUSY) req_ready[mux_sel] = take;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mux_sel <= '0;
            last_grant <= 2'd3;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        mux_sel <= winner;
                        beat_cnt <= '0;
                        state <= BUSY;
                    end
                end
                default: begin
                    if (accept) begin
                        if (term) begin
                            state <= IDLE;
                            last_grant <= mux_sel;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // A new accept reloads the stage in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            out_src <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data <= sel_data;
            out_last <= term;
            out_src <= mux_sel;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
